// File: rtl/q_8_34a_pkg.sv
// Shared sizes and controller state encoding for the q_8_34a ones counter.
package q_8_34a_pkg;

  localparam int unsigned data_size = 8;
  localparam int unsigned r2_size   = $clog2(data_size + 1);
  localparam int unsigned cnt_size  = $clog2(data_size + 1);

  // Largest legal number of shifts for one word.
  localparam logic [cnt_size-1:0] cnt_max = cnt_size'(data_size);

  typedef enum logic [2:0] {
    S_IDLE,
    S_1,
    S_2,
    S_3,
    S_ERR
  } ctrl_state_t;

endpackage

// File: rtl/q_8_34a_ctrl_if.sv
// Start/ready/busy/done/err handshake between a requester and the ones-counter controller.
interface q_8_34a_ctrl_if;

  logic start;
  logic ready;
  logic busy;
  logic done;
  logic err;

  modport master (output start, input ready, busy, done, err);
  modport slave  (input start, output ready, busy, done, err);

endinterface

// File: rtl/q_8_34a.sv
// Ones-counter datapath: R1 shifts into E, R2 counts; reset is synchronous active-low.
module q_8_34a
  import q_8_34a_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [data_size-1:0] data_in,
  input  logic                 load_regs,
  input  logic                 shift,
  input  logic                 incr_r2,
  output logic                 zero,
  output logic                 E,
  output logic [r2_size-1:0]   R2
);

  logic [data_size-1:0] r1;
  logic                 e_q;
  logic [r2_size-1:0]   r2_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r1   <= '0;
      e_q  <= 1'b0;
      r2_q <= '0;
    end else if (load_regs) begin
      r1   <= data_in;
      e_q  <= 1'b0;
      r2_q <= '1;
    end else if (shift) begin
      {e_q, r1} <= {r1, 1'b0};
    end else if (incr_r2) begin
      r2_q <= r2_q + 1'b1;
    end
  end

  assign zero = (r1 == '0);
  assign E    = e_q;
  assign R2   = r2_q;

endmodule

// File: rtl/q_8_34a_top.sv
// Integration of the q_8_34a datapath with its controller; controls are exposed for observation.
module q_8_34a_top
  import q_8_34a_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [data_size-1:0] data_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 load_regs,
  output logic                 incr_r2,
  output logic                 shift,
  output logic [r2_size-1:0]   R2
);

  logic zero;
  logic e_flag;

  q_8_34a_ctrl_if hs ();

  assign hs.start = start;
  assign ready    = hs.ready;
  assign busy     = hs.busy;
  assign done     = hs.done;
  assign err      = hs.err;

  q_8_34a_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .hs        (hs),
    .zero      (zero),
    .E         (e_flag),
    .load_regs (load_regs),
    .incr_r2   (incr_r2),
    .shift     (shift)
  );

  q_8_34a u_dp (
    .clk       (clk),
    .rst_b     (~rst),
    .data_in   (data_in),
    .load_regs (load_regs),
    .shift     (shift),
    .incr_r2   (incr_r2),
    .zero      (zero),
    .E         (e_flag),
    .R2        (R2)
  );

endmodule

// File: rtl/q_8_34a_ctrl.sv
// Ones-counter controller: load/shift/count sequencing with a handshake and shift-count watchdog.
module q_8_34a_ctrl
  import q_8_34a_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  q_8_34a_ctrl_if.slave  hs,
  input  logic           zero,
  input  logic           E,
  output logic           load_regs,
  output logic           incr_r2,
  output logic           shift
);

  ctrl_state_t         state, state_nx;
  logic [cnt_size-1:0] cnt, cnt_nx;
  logic                done_q, done_nx;
  logic                err_q, err_nx;
  logic                ready_c, busy_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    done_nx   = 1'b0;
    err_nx    = err_q;
    load_regs = 1'b0;
    incr_r2   = 1'b0;
    shift     = 1'b0;
    ready_c   = 1'b0;
    busy_c    = 1'b0;
    case (state)
      S_IDLE, S_ERR: begin
        ready_c = 1'b1;
        if (hs.start) begin
          load_regs = 1'b1;
          cnt_nx    = '0;
          err_nx    = 1'b0;
          state_nx  = S_1;
        end
      end
      S_1: begin
        busy_c  = 1'b1;
        incr_r2 = 1'b1;
        if (zero) begin
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end else if (cnt == cnt_max) begin
          err_nx   = 1'b1;
          state_nx = S_ERR;
        end else begin
          state_nx = S_2;
        end
      end
      S_2: begin
        busy_c   = 1'b1;
        shift    = 1'b1;
        cnt_nx   = cnt + 1'b1;
        state_nx = S_3;
      end
      S_3: begin
        busy_c = 1'b1;
        if (E) begin
          state_nx = S_1;
        end else if (cnt == cnt_max) begin
          err_nx   = 1'b1;
          state_nx = S_ERR;
        end else begin
          state_nx = S_2;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Controls are forced low in the reset cycle whatever state the FSM holds.
    if (rst) begin
      load_regs = 1'b0;
      incr_r2   = 1'b0;
      shift     = 1'b0;
    end
  end

  assign hs.ready = ready_c;
  assign hs.busy  = busy_c;
  assign hs.done  = done_q;
  assign hs.err   = err_q;

endmodule

// File: tb/tb_q_8_34a_ctrl.sv
// Bench: controller standalone (status tied low) and inside the integration top.
module tb_q_8_34a_ctrl;
  import q_8_34a_pkg::*;

  typedef struct {
    logic [3:0] r2;
    int         busy;
    int         shifts;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       s_ready, s_busy, s_done, s_err, s_load, s_incr, s_shift;
  logic [3:0] s_r2;
  logic       i_zero = 1'b0;
  logic       i_e = 1'b0;
  logic       i_load, i_incr, i_shift;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  q_8_34a_ctrl_if hs_iso ();

  q_8_34a_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .hs        (hs_iso),
    .zero      (i_zero),
    .E         (i_e),
    .load_regs (i_load),
    .incr_r2   (i_incr),
    .shift     (i_shift)
  );

  q_8_34a_top u_sys (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .ready     (s_ready),
    .busy      (s_busy),
    .done      (s_done),
    .err       (s_err),
    .load_regs (s_load),
    .incr_r2   (s_incr),
    .shift     (s_shift),
    .R2        (s_r2)
  );

  function automatic exp_t model(input logic [7:0] d);
    exp_t m;
    int   ones;
    int   low;
    ones = 0;
    low  = -1;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) begin
        ones++;
        if (low < 0) low = i;
      end
    end
    m.r2     = 4'(ones);
    m.shifts = (low < 0) ? 0 : 8 - low;
    m.busy   = ones + 1 + 2 * m.shifts;
    m.err    = 1'b0;
    return m;
  endfunction

  // Drive one accepted start; returns at the negedge of the first busy cycle.
  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    #1;
    n_cmp++;
    if (s_load !== 1'b1 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL start_load d=%h: load=%b ready=%b want 1 1", d, s_load, s_ready);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic observe(input int p0, input int p1, output int busy_c, output int shift_c,
                         output int load_c, output logic got_done, output logic [3:0] r2);
    busy_c = 0; shift_c = 0; load_c = 0; got_done = 1'b0; r2 = 4'h0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      start = (i == p0 || i == p1);
      #1;
      if (s_done) begin
        got_done = 1'b1;
        r2 = s_r2;
      end else begin
        if (s_busy)  busy_c++;
        if (s_shift) shift_c++;
        if (s_load)  load_c++;
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; hs_iso.start = 1'b1; data_in = 8'hFF;
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++;
    if ({s_load, s_incr, s_shift, i_load, i_incr, i_shift} !== 6'b0) begin
      n_bad++;
      $display("FAIL rst_ctrls: got %b want 000000", {s_load, s_incr, s_shift, i_load, i_incr, i_shift});
    end
    start = 1'b0; hs_iso.start = 1'b0; rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({s_ready, s_busy, s_done, s_err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL rst_hs: rdy/busy/done/err=%b want 1000", {s_ready, s_busy, s_done, s_err});
    end
    n_cmp++;
    if ({hs_iso.ready, hs_iso.busy, hs_iso.done, hs_iso.err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL rst_iso: rdy/busy/done/err=%b want 1000",
               {hs_iso.ready, hs_iso.busy, hs_iso.done, hs_iso.err});
    end
  endtask

  task automatic test_count(input logic [7:0] d, input int p0, input int p1);
    int         bc, sc, lc;
    logic       gd;
    logic [3:0] r2;
    exp_t       e;
    sbq.push_back(model(d));
    pulse_start(d);
    observe(p0, p1, bc, sc, lc, gd, r2);
    e = sbq.pop_front();
    n_cmp++;
    if (gd !== 1'b1) begin
      n_bad++;
      $display("FAIL cnt_done d=%h: no done within bound, want done", d);
    end
    n_cmp++;
    if (r2 !== e.r2) begin
      n_bad++;
      $display("FAIL cnt_r2 d=%h: got %0d want %0d", d, r2, e.r2);
    end
    n_cmp++;
    if (bc != e.busy || sc != e.shifts) begin
      n_bad++;
      $display("FAIL cnt_timing d=%h: busy=%0d shifts=%0d want %0d %0d", d, bc, sc, e.busy, e.shifts);
    end
    n_cmp++;
    if (lc != 0 || s_err !== e.err) begin
      n_bad++;
      $display("FAIL cnt_misc d=%h: busy loads=%0d err=%b want 0 %b", d, lc, s_err, e.err);
    end
  endtask

  task automatic test_back_to_back();
    int         bc, sc, lc;
    logic       gd;
    logic [3:0] r2;
    exp_t       e;
    sbq.push_back(model(8'h00));
    pulse_start(8'h00);
    observe(-1, -1, bc, sc, lc, gd, r2);
    e = sbq.pop_front();
    n_cmp++;
    if (gd !== 1'b1 || r2 !== e.r2 || bc != e.busy) begin
      n_bad++;
      $display("FAIL b2b_first: done=%b r2=%0d busy=%0d want 1 %0d %0d", gd, r2, bc, e.r2, e.busy);
    end
    // Start in the done cycle itself.
    sbq.push_back(model(8'h03));
    data_in = 8'h03;
    start = 1'b1;
    #1;
    n_cmp++;
    if (s_load !== 1'b1 || s_done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_load: load=%b done=%b want 1 1", s_load, s_done);
    end
    @(negedge clk);
    start = 1'b0;
    observe(-1, -1, bc, sc, lc, gd, r2);
    e = sbq.pop_front();
    n_cmp++;
    if (gd !== 1'b1 || r2 !== e.r2 || bc != e.busy) begin
      n_bad++;
      $display("FAIL b2b_second: done=%b r2=%0d busy=%0d want 1 %0d %0d", gd, r2, bc, e.r2, e.busy);
    end
  endtask

  task automatic test_watchdog();
    int   bc, sc, dc;
    logic seen;
    exp_t e;
    exp_t w;
    w.r2 = 4'h0; w.shifts = 8; w.busy = 1 + 2 * 8; w.err = 1'b1;
    sbq.push_back(w);
    bc = 0; sc = 0; dc = 0; seen = 1'b0;
    @(negedge clk);
    hs_iso.start = 1'b1;
    #1;
    n_cmp++;
    if (i_load !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_load: got %b want 1", i_load);
    end
    @(negedge clk);
    hs_iso.start = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1;
      if (hs_iso.err) seen = 1'b1;
      else begin
        if (hs_iso.busy) bc++;
        if (i_shift)     sc++;
        if (hs_iso.done) dc++;
        @(negedge clk);
      end
    end
    e = sbq.pop_front();
    n_cmp++;
    if (seen !== e.err || sc != e.shifts || bc != e.busy || dc != 0) begin
      n_bad++;
      $display("FAIL wd_trip: err=%b shifts=%0d busy=%0d dones=%0d want %b %0d %0d 0",
               seen, sc, bc, dc, e.err, e.shifts, e.busy);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({hs_iso.err, hs_iso.ready, hs_iso.busy, i_load, i_incr, i_shift} !== 6'b110000) begin
      n_bad++;
      $display("FAIL wd_sticky: err/rdy/busy/ctl=%b want 110000",
               {hs_iso.err, hs_iso.ready, hs_iso.busy, i_load, i_incr, i_shift});
    end
    hs_iso.start = 1'b1;
    #1;
    n_cmp++;
    if (i_load !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_restart_load: got %b want 1", i_load);
    end
    @(negedge clk);
    hs_iso.start = 1'b0;
    #1;
    n_cmp++;
    if (hs_iso.err !== 1'b0 || hs_iso.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_clear: err=%b busy=%b want 0 1", hs_iso.err, hs_iso.busy);
    end
  endtask

  task automatic test_mid_reset();
    pulse_start(8'hFF);
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++;
    if (s_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mr_busy3: busy=%b want 1", s_busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({s_load, s_incr, s_shift} !== 3'b000) begin
      n_bad++;
      $display("FAIL mr_rst_ctrls: got %b want 000", {s_load, s_incr, s_shift});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({s_ready, s_busy, s_done, s_err, s_load, s_incr, s_shift} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL mr_after: rdy/busy/done/err/ctl=%b want 1000000",
               {s_ready, s_busy, s_done, s_err, s_load, s_incr, s_shift});
    end
    test_count(8'h03, -1, -1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    hs_iso.start = 1'b0;
    test_reset();
    test_count(8'h00, -1, -1);
    test_count(8'h80, -1, -1);
    test_count(8'h01, -1, -1);
    test_count(8'hA5, 3, 10);
    test_back_to_back();
    test_watchdog();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
